// File: rtl/trig_sequencer_if.sv
// Host/stimulus bus of the trigger sequencer: burst control, configuration and status.
// The host side uses the master modport, the sequencer the slave modport.
interface trig_sequencer_if;
  logic        start;
  logic        abort;
  logic [19:0] num_trig;
  logic [31:0] period;
  logic        trig_to_siggen;
  logic        window_open;
  logic        busy;
  logic        done;
  logic [19:0] trig_count;

  modport master (
    output start, abort, num_trig, period,
    input  trig_to_siggen, window_open, busy, done, trig_count
  );

  modport slave (
    input  start, abort, num_trig, period,
    output trig_to_siggen, window_open, busy, done, trig_count
  );
endinterface

// File: rtl/trig_sequencer.sv
// Trigger burst sequencer: num_trig pulses at a clamped period, one per measurement window.
// Optional random gap extension is built only when RAND_GAP_EN is defined.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  S_IDLE   | waiting for start; abort flag cleared
//  S_PULSE  | trig_to_siggen high, pulse down-counter running
//  S_GAP    | trig low, waiting for period counter terminal count
//  S_FINISH | burst over, waiting for last window to close, then done
module trig_sequencer #(
  parameter int unsigned PULSE_CYC  = 10,
  parameter int unsigned WINDOW_CYC = 300001,
  parameter int unsigned MIN_PERIOD = 300008
`ifdef RAND_GAP_EN
  ,
  parameter int unsigned DITHER_BITS = 12,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
`endif
) (
  input  logic             clki,
  input  logic             reset_n,
  trig_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PULSE  = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int unsigned PCW = $clog2(PULSE_CYC);
  localparam int unsigned WCW = $clog2(WINDOW_CYC);
  localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_CYC - 1);
  localparam logic [WCW-1:0] WIN_LOAD   = WCW'(WINDOW_CYC - 1);
  localparam logic [31:0]    MIN_P      = MIN_PERIOD;
  localparam logic [19:0]    CNT_MAX    = '1;

  logic [1:0]     state;
  logic [19:0]    num_lat;
  logic [31:0]    eff_period;
  logic [31:0]    period_cnt;
  logic [PCW-1:0] pulse_cnt;
  logic [WCW-1:0] win_cnt;
  logic           abort_pend;
  logic           trig_q;
  logic           window_q;
  logic           busy_q;
  logic           done_q;
  logic [19:0]    trig_count_q;

  logic           start_ok;
  logic           abort_now;
  logic           rise;
  logic [31:0]    eff_in;
  logic [31:0]    spacing_base;
  logic [31:0]    spacing;
  logic [31:0]    period_load;

  assign start_ok     = (state == S_IDLE) && bus.start && !bus.abort;
  assign abort_now    = bus.abort || abort_pend;
  assign eff_in       = (bus.period < MIN_P) ? MIN_P : bus.period;
  // On the first trigger eff_period is being latched on the same edge.
  assign spacing_base = (state == S_IDLE) ? eff_in : eff_period;

`ifdef RAND_GAP_EN
  logic [15:0] lfsr;
  logic [32:0] spacing_sum;

  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else if (rise) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Dither is drawn from the LFSR value present at the rising edge; saturate, never wrap.
  assign spacing_sum = {1'b0, spacing_base} + 33'(lfsr[DITHER_BITS-1:0]);
  assign spacing     = spacing_sum[32] ? 32'hFFFF_FFFF : spacing_sum[31:0];
`else
  assign spacing = spacing_base;
`endif

  assign period_load = spacing - 32'd1;

  always_comb begin
    rise = 1'b0;
    case (state)
      S_IDLE:  rise = start_ok && (bus.num_trig != 20'd0);
      S_GAP:   rise = !abort_now && (trig_count_q < num_lat) && (period_cnt == 32'd0);
      default: rise = 1'b0;
    endcase
  end

  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      num_lat      <= '0;
      eff_period   <= '0;
      period_cnt   <= '0;
      pulse_cnt    <= '0;
      abort_pend   <= 1'b0;
      trig_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trig_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (period_cnt != 32'd0) begin
        period_cnt <= period_cnt - 32'd1;
      end
      if (rise) begin
        trig_q     <= 1'b1;
        pulse_cnt  <= PULSE_LOAD;
        period_cnt <= period_load;
        if (state == S_IDLE) begin
          trig_count_q <= 20'd1;
        end else if (trig_count_q != CNT_MAX) begin
          trig_count_q <= trig_count_q + 20'd1;
        end
      end

      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (start_ok) begin
            num_lat    <= bus.num_trig;
            eff_period <= eff_in;
            busy_q     <= 1'b1;
            if (bus.num_trig == 20'd0) begin
              trig_count_q <= '0;
              state        <= S_FINISH;
            end else begin
              state <= S_PULSE;
            end
          end
        end
        S_PULSE: begin
          if (bus.abort) begin
            abort_pend <= 1'b1;
          end
          // A pending abort never shortens the pulse; it is acted on in S_GAP.
          if (pulse_cnt == '0) begin
            trig_q <= 1'b0;
            state  <= S_GAP;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (bus.abort) begin
            abort_pend <= 1'b1;
          end
          if (rise) begin
            state <= S_PULSE;
          end else if (abort_now || (trig_count_q >= num_lat)) begin
            state <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (!window_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Measurement window runs on its own counter so it outlives the pulse and the FSM state.
  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      window_q <= 1'b0;
      win_cnt  <= '0;
    end else if (rise) begin
      window_q <= 1'b1;
      win_cnt  <= WIN_LOAD;
    end else if (window_q) begin
      if (win_cnt == '0) begin
        window_q <= 1'b0;
      end else begin
        win_cnt <= win_cnt - 1'b1;
      end
    end
  end

  assign bus.trig_to_siggen = trig_q;
  assign bus.window_open    = window_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.trig_count     = trig_count_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// Randomized self-checking bench for trig_sequencer with shortened window/period parameters.
module tb_trig_sequencer;
  localparam int P    = 10;
  localparam int W    = 301;
  localparam int MINP = 308;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  trig_sequencer_if bus ();

  trig_sequencer #(
    .PULSE_CYC  (P),
    .WINDOW_CYC (W),
    .MIN_PERIOD (MINP)
  ) dut (
    .clki    (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: records cycle numbers of edges seen on the outputs.
  int rises[$];
  int widths[$];
  int wwidths[$];
  int dones[$];
  int done_cnt[$];
  int busy_rises = 0;
  int busy_rise_cyc = -1;
  int busy_fall_cyc = -1;
  int t_start = 0;
  int w_start = 0;
  logic p_trig = 1'b0, p_win = 1'b0, p_busy = 1'b0;

  always @(negedge clk) begin
    if (bus.trig_to_siggen && !p_trig) begin rises.push_back(cyc); t_start = cyc; end
    if (!bus.trig_to_siggen && p_trig) widths.push_back(cyc - t_start);
    if (bus.window_open && !p_win) w_start = cyc;
    if (!bus.window_open && p_win) wwidths.push_back(cyc - w_start);
    if (bus.done) begin dones.push_back(cyc); done_cnt.push_back(int'(bus.trig_count)); end
    if (bus.busy && !p_busy) begin busy_rises++; busy_rise_cyc = cyc; end
    if (!bus.busy && p_busy) busy_fall_cyc = cyc;
    p_trig = bus.trig_to_siggen;
    p_win  = bus.window_open;
    p_busy = bus.busy;
  end

  task automatic clear_mon();
    rises.delete(); widths.delete(); wwidths.delete(); dones.delete(); done_cnt.delete();
    busy_rises = 0; busy_rise_cyc = -1; busy_fall_cyc = -1;
  endtask

  // Runs one burst; offsets are relative to the start cycle, 0 means unused.
  task automatic run_burst(input int num, input int per, input int abort_off,
                           input int stray_off, input string tag);
    int s, eff, a, issued, last, f, exp_done, budget, waited;
    int exp_rises[$];
    @(negedge clk);
    clear_mon();
    s = cyc;
    bus.num_trig = 20'(num);
    bus.period   = 32'(per);
    bus.start    = 1'b1;
    eff = (per < MINP) ? MINP : per;
    for (int k = 0; k < num; k++) exp_rises.push_back(s + 1 + k * eff);
    a = s + abort_off;
    if (abort_off > 0) begin
      while (exp_rises.size() > 1 && exp_rises[exp_rises.size()-1] > a) void'(exp_rises.pop_back());
    end
    issued = exp_rises.size();
    if (num == 0) begin
      exp_done = s + 2;
    end else begin
      last = exp_rises[issued-1];
      f = last + P + 1;
      if (abort_off > 0 && issued < num && a > last + P) f = a + 1;
      exp_done = ((f > last + W) ? f : last + W) + 1;
    end
    budget = exp_done - s + 50;
    waited = 0;
    while (dones.size() == 0 && waited < budget) begin
      @(negedge clk);
      bus.start = (stray_off > 0 && cyc == s + stray_off);
      bus.abort = (abort_off > 0 && cyc == a);
      waited++;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (5) @(negedge clk);

    n_checks++;
    if (dones.size() !== 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d required 1", tag, dones.size());
    end
    n_checks++;
    if (rises.size() !== issued) begin
      n_fail++;
      $display("FAIL %s trig_rises: got %0d required %0d", tag, rises.size(), issued);
    end
    for (int i = 0; i < issued && i < rises.size(); i++) begin
      n_checks++;
      if (rises[i] !== exp_rises[i]) begin
        n_fail++;
        $display("FAIL %s rise_cycle[%0d]: got %0d required %0d", tag, i, rises[i] - s, exp_rises[i] - s);
      end
    end
    for (int i = 0; i < widths.size(); i++) begin
      n_checks++;
      if (widths[i] !== P) begin
        n_fail++;
        $display("FAIL %s pulse_width[%0d]: got %0d required %0d", tag, i, widths[i], P);
      end
    end
    for (int i = 0; i < wwidths.size(); i++) begin
      n_checks++;
      if (wwidths[i] !== W) begin
        n_fail++;
        $display("FAIL %s window_width[%0d]: got %0d required %0d", tag, i, wwidths[i], W);
      end
    end
    if (dones.size() > 0) begin
      n_checks++;
      if (dones[0] !== exp_done) begin
        n_fail++;
        $display("FAIL %s done_cycle: got %0d required %0d", tag, dones[0] - s, exp_done - s);
      end
      n_checks++;
      if (done_cnt[0] !== issued) begin
        n_fail++;
        $display("FAIL %s trig_count: got %0d required %0d", tag, done_cnt[0], issued);
      end
    end
    n_checks++;
    if (busy_rises !== 1 || busy_rise_cyc !== s + 1 || busy_fall_cyc !== exp_done) begin
      n_fail++;
      $display("FAIL %s busy_span: got rises=%0d %0d..%0d required 1 %0d..%0d", tag,
               busy_rises, busy_rise_cyc - s, busy_fall_cyc - s, 1, exp_done - s);
    end
  endtask

  task automatic test_reset();
    int s;
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_trig = '0; bus.period = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.trig_to_siggen, bus.window_open, bus.busy, bus.done, bus.trig_count} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_values: got trig=%b win=%b busy=%b done=%b cnt=%0d required all 0",
               bus.trig_to_siggen, bus.window_open, bus.busy, bus.done, bus.trig_count);
    end
    s = cyc;
    bus.num_trig = 20'd3; bus.period = 32'd400; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < s + 4) @(negedge clk);
    n_checks++;
    if (bus.trig_to_siggen !== 1'b1 || bus.busy !== 1'b1 || bus.trig_count !== 20'd1) begin
      n_fail++;
      $display("FAIL reset_pre_pulse: got trig=%b busy=%b cnt=%0d required 1 1 1",
               bus.trig_to_siggen, bus.busy, bus.trig_count);
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.trig_to_siggen, bus.window_open, bus.busy, bus.done, bus.trig_count} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: got trig=%b win=%b busy=%b cnt=%0d required all 0",
               bus.trig_to_siggen, bus.window_open, bus.busy, bus.trig_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();        run_burst(3, 400, 0, 0, "basic");          endtask
  task automatic test_clamp();        run_burst(2, 100, 0, 0, "clamp");          endtask
  task automatic test_zero();         run_burst(0, 500, 0, 0, "zero");           endtask
  task automatic test_abort_pulse();  run_burst(5, 400, 403, 0, "abort_pulse");  endtask
  task automatic test_abort_gap();    run_burst(4, 400, 600, 0, "abort_gap");    endtask
  task automatic test_start_busy();   run_burst(3, 350, 0, 200, "start_busy");   endtask

  task automatic test_idle_abort();
    @(negedge clk);
    clear_mon();
    bus.num_trig = 20'd2; bus.period = 32'd400;
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy_rises !== 0 || dones.size() !== 0 || rises.size() !== 0) begin
      n_fail++;
      $display("FAIL idle_abort: got busy_rises=%0d dones=%0d trigs=%0d required 0 0 0",
               busy_rises, dones.size(), rises.size());
    end
  endtask

  task automatic test_random();
    int num, per, ab, st, eff;
    for (int it = 0; it < 8; it++) begin
      num = $urandom_range(0, 4);
      per = $urandom_range(50, 700);
      eff = (per < MINP) ? MINP : per;
      ab  = (num > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, num * eff + 20) : 0;
      st  = (num > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(2, 300) : 0;
      run_burst(num, per, ab, st, $sformatf("random%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_zero();
    test_abort_pulse();
    test_abort_gap();
    test_idle_abort();
    test_start_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
